// File: rtl/semaforo_pkg.sv
// Shared definitions for the traffic-light controller and its monitor.
// Holds the lamp phase codes, the default dwell times and helper functions
// for phase sequencing and lamp decoding.
package semaforo_pkg;

    // Phase codes are shared with the controller; SYNC doubles as "no valid phase".
    typedef enum logic [1:0] {
        SYNC   = 2'b00,
        GREEN  = 2'b01,
        YELLOW = 2'b10,
        RED    = 2'b11
    } phase_t;

    // Default dwell times in clk cycles and counter widths.
    localparam int GRN_CYC_DEF = 5;
    localparam int YLW_CYC_DEF = 2;
    localparam int RED_CYC_DEF = 4;
    localparam int DW_W_DEF    = 4;
    localparam int CNT_W_DEF   = 8;

    // Legal successor of a phase: G -> Y -> R -> G. SYNC has no successor.
    function automatic phase_t succ(input phase_t p);
        case (p)
            GREEN:   succ = YELLOW;
            YELLOW:  succ = RED;
            RED:     succ = GREEN;
            default: succ = SYNC;
        endcase
    endfunction

    // Lamp decode: exactly one lamp lit gives its phase, anything else gives
    // SYNC, which the monitor treats as an illegal sample.
    function automatic phase_t decode(input logic grn, input logic ylw, input logic red);
        case ({grn, ylw, red})
            3'b100:  decode = GREEN;
            3'b010:  decode = YELLOW;
            3'b001:  decode = RED;
            default: decode = SYNC;
        endcase
    endfunction

endpackage

// File: rtl/semaforo_monitor_if.sv
// Bundle of the monitor's observed lamp lines and its report outputs.
//   in_grn/in_ylw/in_red : lamp lines from the controller (same clock domain)
//   err_clr              : clears err_sticky
//   phase                : tracked phase code (SYNC/GREEN/YELLOW/RED)
//   err_onehot/order/time: single-cycle error pulses
//   err_sticky           : OR of all pulses since the last clear
//   dwell_last           : dwell of the phase that just ended
//   cycle_cnt            : number of legal RED->GREEN transitions, wraps
// Handshake: none. Lamp lines are sampled every rising clk edge; report
// outputs are registered and valid every cycle, pulses last exactly one cycle.
// The master side drives the lamps and err_clr; the slave side is the monitor.
interface semaforo_monitor_if #(
    parameter int DW_W  = 4,
    parameter int CNT_W = 8
);
    logic             in_grn;
    logic             in_ylw;
    logic             in_red;
    logic             err_clr;
    logic [1:0]       phase;
    logic             err_onehot;
    logic             err_order;
    logic             err_time;
    logic             err_sticky;
    logic [DW_W-1:0]  dwell_last;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output in_grn, in_ylw, in_red, err_clr,
        input  phase, err_onehot, err_order, err_time, err_sticky, dwell_last, cycle_cnt
    );

    modport slave (
        input  in_grn, in_ylw, in_red, err_clr,
        output phase, err_onehot, err_order, err_time, err_sticky, dwell_last, cycle_cnt
    );
endinterface

// File: rtl/semaforo_dwell_cnt.sv
// Saturating dwell counter.
//   clk, rst : clock and synchronous active-high reset
//   clr      : force count to 0
//   load1    : force count to 1 (first cycle of a new phase)
//   inc      : count up by one, holding at all-ones
//   count    : current dwell value
// Priority: rst/clr over load1 over inc.
module semaforo_dwell_cnt #(
    parameter int DW_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            load1,
    input  logic            inc,
    output logic [DW_W-1:0] count
);

    localparam logic [DW_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load1) begin
            count <= DW_W'(1);
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/semaforo_monitor.sv
// Passive checker for the traffic-light controller lamps.
// Samples the three lamp lines, tracks the phase, measures each phase dwell
// and reports lamp-encoding, phase-order and dwell-time errors. Counts
// complete G-Y-R cycles as legal RED->GREEN transitions.
//   clk, rst : clock and synchronous active-high reset
//   mon      : lamp inputs, err_clr and all report outputs (slave side)
// Pipeline: lamps are registered (stage 1), then the FSM and report outputs
// update on the following edge (stage 2). Each *_CYC must be below
// 2**DW_W-1 so a saturated dwell can never match a required value.
module semaforo_monitor
    import semaforo_pkg::*;
#(
    parameter int GRN_CYC = GRN_CYC_DEF,
    parameter int YLW_CYC = YLW_CYC_DEF,
    parameter int RED_CYC = RED_CYC_DEF,
    parameter int DW_W    = DW_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    semaforo_monitor_if.slave mon
);

    localparam logic [DW_W-1:0] GRN_REQ = DW_W'(GRN_CYC);
    localparam logic [DW_W-1:0] YLW_REQ = DW_W'(YLW_CYC);
    localparam logic [DW_W-1:0] RED_REQ = DW_W'(RED_CYC);

    // Stage 1: sampled lamps. s_vld keeps the all-zero reset value of the
    // sample registers from being reported as a non-one-hot lamp pattern.
    logic s_grn, s_ylw, s_red, s_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_grn <= 1'b0;
            s_ylw <= 1'b0;
            s_red <= 1'b0;
            s_vld <= 1'b0;
        end else begin
            s_grn <= mon.in_grn;
            s_ylw <= mon.in_ylw;
            s_red <= mon.in_red;
            s_vld <= 1'b1;
        end
    end

    phase_t s_phase;
    logic   s_legal;

    assign s_phase = decode(s_grn, s_ylw, s_red);
    assign s_legal = (s_phase != SYNC);

    // Stage 2: FSM state, partial flag and dwell counter.
    phase_t          state_q, state_d;
    logic            partial_q;
    logic [DW_W-1:0] dwell;

    logic            onehot_d, order_d, time_d;
    logic            dw_clr, dw_load1, dw_inc;
    logic            last_load, cyc_inc;
    logic            partial_set, partial_clr;
    logic [DW_W-1:0] req_cyc;

    semaforo_dwell_cnt #(.DW_W(DW_W)) u_dwell_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (dw_clr),
        .load1 (dw_load1),
        .inc   (dw_inc),
        .count (dwell)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: follow every legal sample (even out of order), drop to
    // SYNC on any illegal sample.
    always_comb begin
        state_d = state_q;
        if (s_vld) begin
            if (!s_legal) begin
                state_d = SYNC;
            end else begin
                state_d = s_phase;
            end
        end
    end

    // Required dwell of the phase currently being tracked.
    always_comb begin
        req_cyc = '0;
        case (state_q)
            GREEN:   req_cyc = GRN_REQ;
            YELLOW:  req_cyc = YLW_REQ;
            RED:     req_cyc = RED_REQ;
            default: req_cyc = '0;
        endcase
    end

    // FSM outputs: error pulses and counter controls for this sample.
    always_comb begin
        onehot_d    = 1'b0;
        order_d     = 1'b0;
        time_d      = 1'b0;
        dw_clr      = 1'b0;
        dw_load1    = 1'b0;
        dw_inc      = 1'b0;
        last_load   = 1'b0;
        cyc_inc     = 1'b0;
        partial_set = 1'b0;
        partial_clr = 1'b0;
        if (s_vld) begin
            if (!s_legal) begin
                onehot_d    = 1'b1;
                dw_clr      = 1'b1;
                partial_set = 1'b1;
            end else if (state_q == SYNC) begin
                // Entry mid-phase: its true length is unknown, so skip checks.
                dw_load1    = 1'b1;
                partial_set = 1'b1;
            end else if (s_phase == state_q) begin
                dw_inc = 1'b1;
            end else begin
                dw_load1    = 1'b1;
                last_load   = 1'b1;
                partial_clr = 1'b1;
                order_d     = (s_phase != succ(state_q));
                time_d      = !partial_q && (dwell != req_cyc);
                cyc_inc     = (state_q == RED) && (s_phase == GREEN);
            end
        end
    end

    assign mon.phase = state_q;

    // Registered report outputs. The sticky flag also takes the pulses that
    // are visible right now, so a clear issued during a pulse cannot win.
    always_ff @(posedge clk) begin
        if (rst) begin
            partial_q      <= 1'b1;
            mon.err_onehot <= 1'b0;
            mon.err_order  <= 1'b0;
            mon.err_time   <= 1'b0;
            mon.err_sticky <= 1'b0;
            mon.dwell_last <= '0;
            mon.cycle_cnt  <= '0;
        end else begin
            if (partial_set) begin
                partial_q <= 1'b1;
            end else if (partial_clr) begin
                partial_q <= 1'b0;
            end
            mon.err_onehot <= onehot_d;
            mon.err_order  <= order_d;
            mon.err_time   <= time_d;
            mon.err_sticky <= (mon.err_sticky & ~mon.err_clr)
                            | mon.err_onehot | mon.err_order | mon.err_time
                            | onehot_d | order_d | time_d;
            if (last_load) begin
                mon.dwell_last <= dwell;
            end
            if (cyc_inc) begin
                mon.cycle_cnt <= mon.cycle_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_semaforo_monitor.sv
// Testbench for semaforo_monitor: directed scenarios plus randomized lamp
// sequences, all compared cycle by cycle against a run-length reference model.
module tb_semaforo_monitor;

    localparam logic [2:0] L_G   = 3'b100;
    localparam logic [2:0] L_Y   = 3'b010;
    localparam logic [2:0] L_R   = 3'b001;
    localparam logic [2:0] L_OFF = 3'b000;
    localparam logic [2:0] L_GR  = 3'b101;

    logic clk = 1'b0;
    logic rst = 1'b1;

    semaforo_monitor_if #(.DW_W(4), .CNT_W(8)) mon_if ();

    semaforo_monitor #(
        .GRN_CYC (5),
        .YLW_CYC (2),
        .RED_CYC (4),
        .DW_W    (4),
        .CNT_W   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mon (mon_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: the current run of identical legal samples, its
    // length, whether the run began after a sync loss, and the report values.
    int m_cur;     // 0 none, 1 green, 2 yellow, 3 red
    int m_run;
    int m_last;
    int m_cyc;
    bit m_first;
    bit m_oh, m_or, m_tm, m_sticky;
    logic [2:0] pend;
    bit pend_vld;

    function automatic int req_of(input int p);
        case (p)
            1:       return 5;
            2:       return 2;
            3:       return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [17:0] exp_vec();
        return {2'(m_cur), m_oh, m_or, m_tm, m_sticky, 4'(m_last), 8'(m_cyc)};
    endfunction

    function automatic logic [17:0] dut_vec();
        return {mon_if.phase, mon_if.err_onehot, mon_if.err_order, mon_if.err_time,
                mon_if.err_sticky, mon_if.dwell_last, mon_if.cycle_cnt};
    endfunction

    task automatic model_reset();
        m_cur = 0; m_run = 0; m_last = 0; m_cyc = 0;
        m_first = 1'b1; m_oh = 1'b0; m_or = 1'b0; m_tm = 1'b0; m_sticky = 1'b0;
        pend = L_OFF; pend_vld = 1'b0;
    endtask

    // Effect of one clock edge on the model: the sample captured one edge
    // earlier is judged now.
    task automatic model_edge(input bit has, input logic [2:0] lamps, input logic clr);
        bit oh, od, tm;
        int v, sat;
        oh = 1'b0; od = 1'b0; tm = 1'b0;
        if (has) begin
            v = (lamps == L_G) ? 1 : (lamps == L_Y) ? 2 : (lamps == L_R) ? 3 : 0;
            if (v == 0) begin
                oh = 1'b1; m_cur = 0; m_run = 0;
            end else if (m_cur == 0) begin
                m_cur = v; m_run = 1; m_first = 1'b1;
            end else if (v == m_cur) begin
                m_run++;
            end else begin
                sat    = (m_run > 15) ? 15 : m_run;
                od     = (v != (m_cur % 3) + 1);
                tm     = !m_first && (sat != req_of(m_cur));
                m_last = sat;
                if (m_cur == 3 && v == 1) m_cyc = (m_cyc + 1) % 256;
                m_cur = v; m_run = 1; m_first = 1'b0;
            end
        end
        m_sticky = (m_sticky && (clr !== 1'b1)) || m_oh || m_or || m_tm || oh || od || tm;
        m_oh = oh; m_or = od; m_tm = tm;
    endtask

    task automatic step(input logic [2:0] lamps, input logic clr);
        mon_if.in_grn  = lamps[2];
        mon_if.in_ylw  = lamps[1];
        mon_if.in_red  = lamps[0];
        mon_if.err_clr = clr;
        @(posedge clk);
        model_edge(pend_vld, pend, clr);
        pend     = lamps;
        pend_vld = !rst;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(L_OFF, 1'b0);
        step(L_OFF, 1'b0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_vec() !== 18'd0) $display("FAIL reset_outputs: got %h expected %h", dut_vec(), 18'd0);
        else passed++;
        step(L_G, 1'b0);
        checks++;
        if (mon_if.phase !== 2'b00) $display("FAIL latency_edge1 phase: got %b expected 00", mon_if.phase);
        else passed++;
        step(L_G, 1'b0);
        checks++;
        if (mon_if.phase !== 2'b01) $display("FAIL latency_edge2 phase: got %b expected 01", mon_if.phase);
        else passed++;
    endtask

    task automatic test_nominal();
        logic [2:0] pat [10] = '{L_G, L_Y, L_R, L_G, L_Y, L_R, L_G, L_Y, L_R, L_G};
        int         len [10] = '{5, 2, 4, 5, 2, 4, 5, 2, 4, 3};
        int pulses = 0;
        int n = 0;
        do_reset();
        for (int s = 0; s < 10; s++) begin
            for (int c = 0; c < len[s]; c++) begin
                step(pat[s], 1'b0);
                n++;
                pulses += int'(mon_if.err_onehot) + int'(mon_if.err_order) + int'(mon_if.err_time);
                checks++;
                if (dut_vec() !== exp_vec()) $display("FAIL nominal cyc %0d: got %h expected %h", n, dut_vec(), exp_vec());
                else passed++;
            end
        end
        checks++;
        if (pulses != 0) $display("FAIL nominal_pulses: got %0d expected 0", pulses);
        else passed++;
        checks++;
        if (mon_if.cycle_cnt !== 8'd3) $display("FAIL nominal_cycle_cnt: got %0d expected 3", mon_if.cycle_cnt);
        else passed++;
        checks++;
        if (mon_if.dwell_last !== 4'd4) $display("FAIL nominal_dwell_last: got %0d expected 4", mon_if.dwell_last);
        else passed++;
        checks++;
        if (mon_if.err_sticky !== 1'b0) $display("FAIL nominal_sticky: got %b expected 0", mon_if.err_sticky);
        else passed++;
    endtask

    task automatic test_short_yellow();
        logic [2:0] pat [7] = '{L_G, L_Y, L_R, L_G, L_Y, L_R, L_G};
        int         len [7] = '{5, 2, 4, 5, 1, 4, 3};
        int t_cnt = 0;
        int t_last = -1;
        int n = 0;
        do_reset();
        for (int s = 0; s < 7; s++) begin
            for (int c = 0; c < len[s]; c++) begin
                step(pat[s], 1'b0);
                n++;
                if (mon_if.err_time === 1'b1) begin
                    t_cnt++;
                    t_last = int'(mon_if.dwell_last);
                end
                checks++;
                if (dut_vec() !== exp_vec()) $display("FAIL short_yellow cyc %0d: got %h expected %h", n, dut_vec(), exp_vec());
                else passed++;
            end
        end
        checks++;
        if (t_cnt != 1) $display("FAIL short_yellow_time_pulses: got %0d expected 1", t_cnt);
        else passed++;
        checks++;
        if (t_last != 1) $display("FAIL short_yellow_dwell_last: got %0d expected 1", t_last);
        else passed++;
        checks++;
        if (mon_if.err_sticky !== 1'b1) $display("FAIL short_yellow_sticky: got %b expected 1", mon_if.err_sticky);
        else passed++;
    endtask

    task automatic test_order();
        logic [2:0] pat [5] = '{L_G, L_Y, L_R, L_G, L_R};
        int         len [5] = '{5, 2, 4, 5, 5};
        int o_cnt = 0;
        int t_cnt = 0;
        int n = 0;
        do_reset();
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < len[s]; c++) begin
                step(pat[s], 1'b0);
                n++;
                o_cnt += int'(mon_if.err_order);
                t_cnt += int'(mon_if.err_time);
                checks++;
                if (dut_vec() !== exp_vec()) $display("FAIL order cyc %0d: got %h expected %h", n, dut_vec(), exp_vec());
                else passed++;
            end
        end
        checks++;
        if (o_cnt != 1) $display("FAIL order_pulses: got %0d expected 1", o_cnt);
        else passed++;
        checks++;
        if (t_cnt != 0) $display("FAIL order_time_pulses: got %0d expected 0", t_cnt);
        else passed++;
        checks++;
        if (mon_if.phase !== 2'b11) $display("FAIL order_phase: got %b expected 11", mon_if.phase);
        else passed++;
        checks++;
        if (mon_if.cycle_cnt !== 8'd1) $display("FAIL order_cycle_cnt: got %0d expected 1", mon_if.cycle_cnt);
        else passed++;
    endtask

    task automatic test_onehot();
        logic [2:0] pat [6] = '{L_G, L_Y, L_R, L_GR, L_G, L_Y};
        int         len [6] = '{5, 2, 4, 2, 3, 3};
        int oh_cnt = 0;
        int oh_sync = 0;
        int t_cnt = 0;
        int n = 0;
        do_reset();
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < len[s]; c++) begin
                step(pat[s], 1'b0);
                n++;
                if (mon_if.err_onehot === 1'b1) begin
                    oh_cnt++;
                    if (mon_if.phase === 2'b00) oh_sync++;
                end
                t_cnt += int'(mon_if.err_time);
                checks++;
                if (dut_vec() !== exp_vec()) $display("FAIL onehot cyc %0d: got %h expected %h", n, dut_vec(), exp_vec());
                else passed++;
            end
        end
        checks++;
        if (oh_cnt != 2) $display("FAIL onehot_pulses: got %0d expected 2", oh_cnt);
        else passed++;
        checks++;
        if (oh_sync != 2) $display("FAIL onehot_phase_sync: got %0d expected 2", oh_sync);
        else passed++;
        checks++;
        if (t_cnt != 0) $display("FAIL onehot_partial_time: got %0d expected 0", t_cnt);
        else passed++;
    endtask

    task automatic test_sticky_clr();
        logic [2:0] pat [5] = '{L_G, L_Y, L_R, L_G, L_Y};
        int         len [5] = '{5, 2, 4, 5, 1};
        int stage = 0;
        int n = 0;
        do_reset();
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < len[s]; c++) begin
                step(pat[s], 1'b0);
                n++;
                checks++;
                if (dut_vec() !== exp_vec()) $display("FAIL sticky cyc %0d: got %h expected %h", n, dut_vec(), exp_vec());
                else passed++;
            end
        end
        for (int c = 0; c < 8; c++) begin
            logic clr;
            clr = (mon_if.err_time === 1'b1) || (stage == 1);
            step(L_R, clr);
            n++;
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL sticky cyc %0d: got %h expected %h", n, dut_vec(), exp_vec());
            else passed++;
            if (stage == 1) begin
                checks++;
                if (mon_if.err_sticky !== 1'b0) $display("FAIL sticky_clear_next: got %b expected 0", mon_if.err_sticky);
                else passed++;
                stage = 2;
            end else if (clr) begin
                checks++;
                if (mon_if.err_sticky !== 1'b1) $display("FAIL sticky_set_wins: got %b expected 1", mon_if.err_sticky);
                else passed++;
                stage = 1;
            end
        end
        checks++;
        if (stage != 2) $display("FAIL sticky_sequence: got stage %0d expected 2", stage);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [2:0] pre [3] = '{L_G, L_Y, L_R};
        int         pln [3] = '{5, 2, 2};
        logic [2:0] pat [5] = '{L_G, L_Y, L_R, L_G, L_Y};
        int         len [5] = '{7, 2, 4, 20, 3};
        int t_cnt = 0;
        int o_cnt = 0;
        int t_last = -1;
        int n = 0;
        do_reset();
        for (int s = 0; s < 3; s++) begin
            for (int c = 0; c < pln[s]; c++) step(pre[s], 1'b0);
        end
        do_reset();
        checks++;
        if (dut_vec() !== 18'd0) $display("FAIL reset_mid_outputs: got %h expected %h", dut_vec(), 18'd0);
        else passed++;
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < len[s]; c++) begin
                step(pat[s], 1'b0);
                n++;
                o_cnt += int'(mon_if.err_order);
                if (mon_if.err_time === 1'b1) begin
                    t_cnt++;
                    t_last = int'(mon_if.dwell_last);
                end
                checks++;
                if (dut_vec() !== exp_vec()) $display("FAIL reset_mid cyc %0d: got %h expected %h", n, dut_vec(), exp_vec());
                else passed++;
            end
        end
        checks++;
        if (t_cnt != 1) $display("FAIL reset_mid_time_pulses: got %0d expected 1", t_cnt);
        else passed++;
        checks++;
        if (t_last != 15) $display("FAIL reset_mid_saturated_dwell: got %0d expected 15", t_last);
        else passed++;
        checks++;
        if (o_cnt != 0) $display("FAIL reset_mid_order_pulses: got %0d expected 0", o_cnt);
        else passed++;
    endtask

    task automatic test_random();
        logic [2:0] bad [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
        int cur = 1;
        int n = 0;
        do_reset();
        for (int seg = 0; seg < 60; seg++) begin
            logic [2:0] p;
            int l;
            int k;
            k = int'($urandom_range(0, 9));
            if (k == 0) begin
                p = bad[$urandom_range(0, 4)];
                l = int'($urandom_range(1, 2));
            end else begin
                if (k == 1) cur = int'($urandom_range(1, 3));
                else        cur = (cur % 3) + 1;
                p = (cur == 1) ? L_G : (cur == 2) ? L_Y : L_R;
                l = ($urandom_range(0, 1) == 1) ? req_of(cur) : int'($urandom_range(1, 7));
                if (k == 2) l = int'($urandom_range(14, 18));
            end
            for (int c = 0; c < l; c++) begin
                step(p, ($urandom_range(0, 7) == 0));
                n++;
                checks++;
                if (dut_vec() !== exp_vec()) $display("FAIL random cyc %0d: got %h expected %h", n, dut_vec(), exp_vec());
                else passed++;
            end
        end
    endtask

    initial begin
        mon_if.in_grn  = 1'b0;
        mon_if.in_ylw  = 1'b0;
        mon_if.in_red  = 1'b0;
        mon_if.err_clr = 1'b0;
        model_reset();
        test_reset();
        test_nominal();
        test_short_yellow();
        test_order();
        test_onehot();
        test_sticky_clr();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
